// File: rtl/sram_req_adapter.sv
// -----------------------------------------------------------------------------
// sram_req_adapter
//
// Valid/ready request front end for sram_wrapper. Each accepted request is
// held for one cycle in the issue stage S1 and then driven onto RW0_*. The
// write data leaves one cycle earlier, in the accept cycle, because the
// wrapper registers RW0_wdata before the macro sees it. Read returns are
// tracked with a RD_LAT-deep valid shift register. They land in a response
// FIFO. A credit counter keeps the FIFO from overflowing, so back-pressure on
// rsp_ready never loses data.
//
// Optional feature: define SRAM_ADAPTER_WACK_EN to make writes consume a
// credit and return a zero-data response, in order with reads.
//
// Ports
//   RW0_clk, RW0_rst_n         clock (rising edge), sync active-low reset
//   req_valid/req_ready        request handshake
//   req_write/addr/wdata       request payload (1 = write)
//   rsp_valid/rsp_ready        response handshake
//   rsp_rdata                  response data (FIFO head)
//   RW0_addr/wdata/en/wmode    to wrapper
//   RW0_rdata                  from wrapper, valid RD_LAT cycles after RW0_en
// -----------------------------------------------------------------------------
module sram_req_adapter #(
  parameter int ADDR_W    = 10,
  parameter int DATA_W    = 16,
  parameter int RD_LAT    = 2,
  parameter int RSP_DEPTH = 6
) (
  input  logic              RW0_clk,
  input  logic              RW0_rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic [DATA_W-1:0] RW0_wdata,
  output logic              RW0_en,
  output logic              RW0_wmode,
  input  logic [DATA_W-1:0] RW0_rdata
);

  localparam int CNT_W = $clog2(RSP_DEPTH + 1);
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(RSP_DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(RSP_DEPTH - 1);

  typedef struct packed {
    logic              vld;
    logic              write;
    logic [ADDR_W-1:0] addr;
  } iss_t;

  // issue stage
  iss_t s1_q, s1_d;

  // read-return tracking
  logic [RD_LAT-1:0] vld_pipe_q, vld_pipe_d;
`ifdef SRAM_ADAPTER_WACK_EN
  logic [RD_LAT-1:0] wack_pipe_q, wack_pipe_d;  // slot carries a write ack
`endif

  // credits and response FIFO
  logic [CNT_W-1:0]  credit_q, credit_d;
  logic [DATA_W-1:0] fifo_q [RSP_DEPTH];
  logic [DATA_W-1:0] fifo_d [RSP_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              acc;
  logic              rsp_gen;
  logic              trk_in;
  logic              push;
  logic              pop;
  logic [DATA_W-1:0] push_data;

  // ---------------------------------------------------------------------------
  // Handshake and wrapper-side outputs. Every output is gated by reset, so it
  // reads zero during reset cycles whatever the registers hold.
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = RW0_rst_n & (credit_q < DEPTH_C);
    acc       = req_valid & req_ready;
`ifdef SRAM_ADAPTER_WACK_EN
    rsp_gen   = acc;
    trk_in    = s1_q.vld;
`else
    rsp_gen   = acc & ~req_write;
    trk_in    = s1_q.vld & ~s1_q.write;
`endif
    // The data leads the command by a cycle. The wrapper's input register
    // realigns the two.
    RW0_wdata = acc ? req_wdata : '0;
    RW0_en    = RW0_rst_n & s1_q.vld;
    RW0_wmode = RW0_en & s1_q.write;
    RW0_addr  = RW0_en ? s1_q.addr : '0;

    rsp_valid = RW0_rst_n & (cnt_q != '0);
    rsp_rdata = rsp_valid ? fifo_q[rd_ptr_q] : '0;
    pop       = rsp_valid & rsp_ready;

    push      = vld_pipe_q[RD_LAT-1];
    push_data = RW0_rdata;
`ifdef SRAM_ADAPTER_WACK_EN
    if (wack_pipe_q[RD_LAT-1]) push_data = '0;
`endif
  end

  // ---------------------------------------------------------------------------
  // Issue stage and tracking shift register
  // ---------------------------------------------------------------------------
  always_comb begin
    s1_d.vld   = acc;
    s1_d.write = acc & req_write;
    s1_d.addr  = acc ? req_addr : '0;

    vld_pipe_d    = vld_pipe_q << 1;
    vld_pipe_d[0] = trk_in;
`ifdef SRAM_ADAPTER_WACK_EN
    wack_pipe_d    = wack_pipe_q << 1;
    wack_pipe_d[0] = s1_q.vld & s1_q.write;
`endif
  end

  // ---------------------------------------------------------------------------
  // Credits: one per response still owed, in flight or buffered. Capping the
  // count at RSP_DEPTH bounds the FIFO occupancy, so a push never finds it full.
  // ---------------------------------------------------------------------------
  always_comb begin
    credit_d = credit_q;
    if (rsp_gen && !pop)      credit_d = credit_q + CNT_W'(1);
    else if (!rsp_gen && pop) credit_d = credit_q - CNT_W'(1);
  end

  // ---------------------------------------------------------------------------
  // Response FIFO. A push and a pop in the same cycle are independent,
  // including with a single entry. The popped entry is the old head, and the
  // pushed entry goes to the tail slot.
  // ---------------------------------------------------------------------------
  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = push_data;
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // ---------------------------------------------------------------------------
  // State. Reset drops in-flight tracking bits. Wrapper data that is still on
  // its way back is therefore never pushed.
  // ---------------------------------------------------------------------------
  always_ff @(posedge RW0_clk) begin
    if (!RW0_rst_n) begin
      s1_q        <= '0;
      vld_pipe_q  <= '0;
`ifdef SRAM_ADAPTER_WACK_EN
      wack_pipe_q <= '0;
`endif
      credit_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) fifo_q[i] <= '0;
    end else begin
      s1_q        <= s1_d;
      vld_pipe_q  <= vld_pipe_d;
`ifdef SRAM_ADAPTER_WACK_EN
      wack_pipe_q <= wack_pipe_d;
`endif
      credit_q    <= credit_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      fifo_q      <= fifo_d;
    end
  end

endmodule

// File: tb/tb_sram_req_adapter.sv
// -----------------------------------------------------------------------------
// tb_sram_req_adapter
//
// Bench for sram_req_adapter. A behavioural stand-in for sram_wrapper sits on
// the RW0_* port. It registers wdata one cycle ahead and returns read data two
// cycles after RW0_en. The response model is a queue of owed responses, each
// with the cycle it may first appear (accept cycle + 4). A shadow memory gives
// the read data, updated in request order.
// -----------------------------------------------------------------------------
module tb_sram_req_adapter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_write;
  logic [9:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_rdata;
  logic [9:0]  RW0_addr;
  logic [15:0] RW0_wdata;
  logic        RW0_en, RW0_wmode;
  logic [15:0] RW0_rdata;

  always #5 clk = ~clk;

  sram_req_adapter dut (
    .RW0_clk   (clk),
    .RW0_rst_n (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .RW0_addr  (RW0_addr),
    .RW0_wdata (RW0_wdata),
    .RW0_en    (RW0_en),
    .RW0_wmode (RW0_wmode),
    .RW0_rdata (RW0_rdata)
  );

  // Wrapper stand-in. The memory is preloaded with data = addr*3.
  logic [15:0] mem [1024];
  logic [15:0] wd_q;
  logic [15:0] rd_q1;
  bit          mem_init = 1'b0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 16'(i * 3);
      mem_init <= 1'b1;
    end else if (RW0_en) begin
      if (RW0_wmode) mem[RW0_addr] <= wd_q;
      else           rd_q1 <= mem[RW0_addr];
    end
    wd_q      <= RW0_wdata;
    RW0_rdata <= rd_q1;
  end

  // ---------------------------------------------------------------------------
  // Reference model
  // ---------------------------------------------------------------------------
  typedef struct { logic [15:0] data; int avail; } rsp_t;
  rsp_t        rq[$];
  logic [15:0] ref_mem [1024];
  int          outst = 0;     // responses owed (credits in use)
  logic        p_acc = 1'b0;  // request accepted last cycle
  logic        p_w   = 1'b0;
  logic [9:0]  p_a   = '0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;
  int          hs_cnt = 0;
  int          rsp_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive, check at the falling edge, advance the model.
  task automatic step(input logic rs, input logic v, input logic w, input logic [9:0] a,
                      input logic [15:0] d, input logic rr, output logic acc_o);
    logic        e_ready, e_valid, e_en, acc;
    logic [15:0] e_rdata;
    rst_n = rs; req_valid = v; req_write = w; req_addr = a; req_wdata = d; rsp_ready = rr;
    @(negedge clk);
    e_ready = rs && (outst < 6);
    e_valid = 1'b0;
    e_rdata = '0;
    if (rs && rq.size() > 0) begin
      if (rq[0].avail <= cyc) begin
        e_valid = 1'b1;
        e_rdata = rq[0].data;
      end
    end
    acc  = v && e_ready;
    e_en = rs && p_acc;
    chk("req_ready", req_ready, e_ready);
    chk("rsp_valid", rsp_valid, e_valid);
    if (e_valid || !rs) chk("rsp_rdata", rsp_rdata, e_rdata);
    chk("RW0_en", RW0_en, e_en);
    chk("RW0_wmode", RW0_wmode, e_en && p_w);
    chk("RW0_addr", RW0_addr, e_en ? p_a : 10'd0);
    chk("RW0_wdata", RW0_wdata, acc ? d : 16'd0);
    if (v && req_ready) hs_cnt++;
    if (rsp_valid && rr) rsp_cnt++;
    if (!rs) begin
      rq.delete();
      outst = 0;
      p_acc = 1'b0;
    end else begin
      if (e_valid && rr) begin
        void'(rq.pop_front());
        outst--;
      end
      p_acc = acc; p_w = w; p_a = a;
      if (acc) begin
        if (w) begin
          ref_mem[a] = d;
`ifdef SRAM_ADAPTER_WACK_EN
          rq.push_back('{data: 16'h0000, avail: cyc + 4});
          outst++;
`endif
        end else begin
          rq.push_back('{data: ref_mem[a], avail: cyc + 4});
          outst++;
        end
      end
    end
    acc_o = acc;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors: reset, then write 0xBEEF to 0x005 and read it back.
  // ---------------------------------------------------------------------------
  typedef struct {
    logic rst, v, w; logic [9:0] a; logic [15:0] d; logic rr;
    logic e_ready, e_en, e_wm; logic [9:0] e_addr; logic [15:0] e_wd;
    logic e_valid; logic [15:0] e_rdata;
  } vec_t;
  vec_t tbl [11];

  initial begin
    logic acc;
    int   k;
    //           rst v  w  addr   wdata      rr | rdy en wm addr   wd         vld rdata
    tbl[0]  = '{0, 1, 1, 10'h5, 16'hBEEF, 0,    0,  0, 0, 10'h0, 16'h0,    0, 16'h0};
    tbl[1]  = '{0, 1, 1, 10'h5, 16'hBEEF, 0,    0,  0, 0, 10'h0, 16'h0,    0, 16'h0};
    tbl[2]  = '{0, 1, 1, 10'h5, 16'hBEEF, 0,    0,  0, 0, 10'h0, 16'h0,    0, 16'h0};
    tbl[3]  = '{1, 0, 0, 10'h0, 16'h0,    1,    1,  0, 0, 10'h0, 16'h0,    0, 16'h0};
    tbl[4]  = '{1, 1, 1, 10'h5, 16'hBEEF, 1,    1,  0, 0, 10'h0, 16'hBEEF, 0, 16'h0};
    tbl[5]  = '{1, 1, 0, 10'h5, 16'h1234, 1,    1,  1, 1, 10'h5, 16'h1234, 0, 16'h0};
    tbl[6]  = '{1, 0, 0, 10'h0, 16'h0,    1,    1,  1, 0, 10'h5, 16'h0,    0, 16'h0};
    tbl[7]  = '{1, 0, 0, 10'h0, 16'h0,    1,    1,  0, 0, 10'h0, 16'h0,    0, 16'h0};
`ifdef SRAM_ADAPTER_WACK_EN
    tbl[8]  = '{1, 0, 0, 10'h0, 16'h0,    1,    1,  0, 0, 10'h0, 16'h0,    1, 16'h0};
`else
    tbl[8]  = '{1, 0, 0, 10'h0, 16'h0,    1,    1,  0, 0, 10'h0, 16'h0,    0, 16'h0};
`endif
    tbl[9]  = '{1, 0, 0, 10'h0, 16'h0,    1,    1,  0, 0, 10'h0, 16'h0,    1, 16'hBEEF};
    tbl[10] = '{1, 0, 0, 10'h0, 16'h0,    1,    1,  0, 0, 10'h0, 16'h0,    0, 16'h0};

    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'(i * 3);
    rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
    rsp_ready = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 11; i++) begin
      rst_n = tbl[i].rst; req_valid = tbl[i].v; req_write = tbl[i].w;
      req_addr = tbl[i].a; req_wdata = tbl[i].d; rsp_ready = tbl[i].rr;
      @(negedge clk);
      chk($sformatf("t%0d_req_ready", i), req_ready, tbl[i].e_ready);
      chk($sformatf("t%0d_RW0_en", i), RW0_en, tbl[i].e_en);
      chk($sformatf("t%0d_RW0_wmode", i), RW0_wmode, tbl[i].e_wm);
      chk($sformatf("t%0d_RW0_addr", i), RW0_addr, tbl[i].e_addr);
      chk($sformatf("t%0d_RW0_wdata", i), RW0_wdata, tbl[i].e_wd);
      chk($sformatf("t%0d_rsp_valid", i), rsp_valid, tbl[i].e_valid);
      if (tbl[i].e_valid || !tbl[i].rst)
        chk($sformatf("t%0d_rsp_rdata", i), rsp_rdata, tbl[i].e_rdata);
      @(posedge clk);
      cyc++;
      #1;
    end
    ref_mem[5] = 16'hBEEF;

    // Streaming: restore addr 5, then 8 back-to-back reads of 0..7.
    step(1, 1, 1, 10'd5, 16'd15, 1, acc);
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 0, 1, acc);
    rsp_cnt = 0;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 10'(i), 16'd0, 1, acc);
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 1, acc);
    chk("stream_rsp_count", rsp_cnt, 8);

    // Backpressure: 10 reads offered with rsp_ready low.
    hs_cnt = 0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 0, 10'(20 + k), 16'd0, 0, acc);
      if (acc) k++;
    end
    chk("bp_accepted", hs_cnt, 6);
    for (int i = 0; i < 30; i++) begin
      if (k < 10) begin
        step(1, 1, 0, 10'(20 + k), 16'd0, 1, acc);
        if (acc) k++;
      end else begin
        step(1, 0, 0, 0, 0, 1, acc);
      end
    end

    // Reset mid-burst: 3 reads in flight, a one-cycle reset pulse.
    for (int i = 1; i <= 3; i++) step(1, 1, 0, 10'(i), 16'd0, 1, acc);
    step(0, 1, 0, 10'd4, 16'd0, 1, acc);
    rsp_cnt = 0;
    for (int i = 0; i < 8; i++) step(1, 0, 0, 0, 0, 1, acc);
    chk("rst_no_rsp", rsp_cnt, 0);
    hs_cnt = 0;
    for (int i = 0; i < 8; i++) step(1, 1, 0, 10'(40 + i), 16'd0, 0, acc);
    chk("rst_credit_restart", hs_cnt, 6);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 1, acc);

    // Randomized mix on a small address range so read-after-write hits occur.
    for (int i = 0; i < 400; i++)
      step(1, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
           10'($urandom_range(0, 15)), 16'($urandom), $urandom_range(0, 3) != 0, acc);
    for (int i = 0; i < 12; i++) step(1, 0, 0, 0, 0, 1, acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
